mux2_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 2:1 datapath mux between two valid/ready requesters and drives the mux `select`. It sits directly in front of a `mux2` instance. Requester 0 connects to `in0` and requester 1 connects to `in1`. The mux output feeds a single downstream consumer. Grants are held for a bounded burst, so neither requester can starve the other.

---
 rtl/mux2_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// Module   : mux2_rr_arbiter
// Brief    : Round-robin, burst-bounded arbiter that drives the select of a
//            shared 2:1 datapath mux between two valid/ready requesters.
//            Optional per-requester beat counters under MUX2_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid0,
    input  logic             valid1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             ready0,
    output logic             ready1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef MUX2_ARB_STATS_EN
    ,
    output logic [15:0]      beats0,
    output logic [15:0]      beats1
`endif
);

    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [7:0] w_cnt_inc;
    logic       r_sel;
    logic       w_sel_next;
    logic       r_last;
    logic       w_last_next;
    logic       w_rearb;
    logic       w_win;
    logic       w_out_valid;
    logic       w_ready0;
    logic       w_ready1;

    assign w_cnt_inc = r_cnt + 8'd1;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sel_next   = r_sel;
        w_last_next  = r_last;
        w_rearb      = 1'b0;
        w_win        = 1'b0;
        w_out_valid  = 1'b0;
        w_ready0     = 1'b0;
        w_ready1     = 1'b0;

        case (r_state)
            S_GNT0: begin
                w_out_valid = valid0;
                w_ready0    = valid0 & out_ready;
                if (!valid0) begin
                    w_last_next = 1'b0;
                    w_rearb     = 1'b1;
                end else if (w_ready0) begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == c_max_burst) begin
                        w_last_next = 1'b0;
                        w_rearb     = 1'b1;
                    end
                end
            end
            S_GNT1: begin
                w_out_valid = valid1;
                w_ready1    = valid1 & out_ready;
                if (!valid1) begin
                    w_last_next = 1'b1;
                    w_rearb     = 1'b1;
                end else if (w_ready1) begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == c_max_burst) begin
                        w_last_next = 1'b1;
                        w_rearb     = 1'b1;
                    end
                end
            end
            default: begin
                w_rearb = 1'b1;
            end
        endcase

        // Arbitration uses the freshly updated last-served value so a grant
        // ending this cycle hands off directly to a waiting peer.
        if (w_rearb) begin
            if (valid0 && valid1) begin
                w_win = ~w_last_next;
            end else begin
                w_win = valid1;
            end
            if (valid0 || valid1) begin
                w_state_next = w_win ? S_GNT1 : S_GNT0;
                w_sel_next   = w_win;
                w_cnt_next   = 8'd0;
            end else begin
                w_state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_sel   <= w_sel_next;
            r_last  <= w_last_next;
        end
    end

    assign sel       = r_sel;
    assign out_valid = w_out_valid;
    assign ready0    = w_ready0;
    assign ready1    = w_ready1;
    assign out_data  = r_sel ? data1 : data0;

`ifdef MUX2_ARB_STATS_EN
    logic [15:0] r_beats0;
    logic [15:0] r_beats1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beats0 <= 16'd0;
            r_beats1 <= 16'd0;
        end else begin
            if (w_ready0) r_beats0 <= r_beats0 + 16'd1;
            if (w_ready1) r_beats1 <= r_beats1 + 16'd1;
        end
    end

    assign beats0 = r_beats0;
    assign beats1 = r_beats1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux2_rr_arbiter
// Brief    : Self-checking bench for mux2_rr_arbiter: vector table, directed
//            corner sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid0, valid1;
    logic [WIDTH-1:0] data0, data1;
    logic             ready0, ready1;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
`ifdef MUX2_ARB_STATS_EN
    logic [15:0]      beats0, beats1;
`endif

    mux2_rr_arbiter #(
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid0    (valid0),
        .valid1    (valid1),
        .data0     (data0),
        .data1     (data1),
        .ready0    (ready0),
        .ready1    (ready1),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef MUX2_ARB_STATS_EN
        ,
        .beats0    (beats0),
        .beats1    (beats1)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       v0;
        logic       v1;
        logic       ordy;
        logic       r0;
        logic       r1;
        logic       sel;
        logic       ov;
        logic [7:0] od;
    } vec_t;

    vec_t tbl[21];

    // Reference model: who owns the mux, beats in the current grant,
    // who was served last, and beats accepted per requester.
    int   m_owner;
    int   m_cnt;
    int   m_last;
    logic m_sel;
    int   m_b0, m_b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        valid0    = 1'b0;
        valid1    = 1'b0;
        out_ready = 1'b0;
        data0     = 8'h3C;
        data1     = 8'hC3;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_ready0", 32'(ready0), 32'd0);
        chk("rst_ready1", 32'(ready1), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h3C);
        reset = 1'b0;
    endtask

    task automatic step(input string tag, input logic v0, input logic v1,
                        input logic [7:0] d0, input logic [7:0] d1, input logic ordy,
                        input logic er0, input logic er1, input logic esel,
                        input logic eov, input logic [7:0] eod);
        valid0    = v0;
        valid1    = v1;
        data0     = d0;
        data1     = d1;
        out_ready = ordy;
        #1;
        chk({tag, "_ready0"}, 32'(ready0), 32'(er0));
        chk({tag, "_ready1"}, 32'(ready1), 32'(er1));
        chk({tag, "_sel"}, 32'(sel), 32'(esel));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(eov));
        chk({tag, "_out_data"}, 32'(out_data), 32'(eod));
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 1;
        m_sel   = 1'b0;
        m_b0    = 0;
        m_b1    = 0;
    endtask

    task automatic model_pick(input logic a0, input logic a1);
        if (a0 && a1)  m_owner = 1 - m_last;
        else if (a0)   m_owner = 0;
        else if (a1)   m_owner = 1;
        else           m_owner = -1;
        if (m_owner >= 0) begin
            m_cnt = 0;
            m_sel = (m_owner == 1);
        end
    endtask

    task automatic model_step(input logic a0, input logic a1, input logic ordy);
        logic act;
        if (m_owner < 0) begin
            model_pick(a0, a1);
        end else begin
            act = (m_owner == 0) ? a0 : a1;
            if (!act) begin
                m_last = m_owner;
                model_pick(a0, a1);
            end else if (ordy) begin
                if (m_owner == 0) m_b0++; else m_b1++;
                m_cnt++;
                if (m_cnt == MAX_BURST) begin
                    m_last = m_owner;
                    model_pick(a0, a1);
                end
            end
        end
    endtask

    initial begin
        logic       h0, h1;
        logic [7:0] rd0, rd1;
        logic       e_r0, e_r1, e_ov;
        logic [7:0] e_od;

        // Table: both valid after reset, rotation, a 5-cycle stall in GNT1,
        // a mid-burst valid drop and a return through IDLE.
        tbl[0]  = '{1, 1, 1, 0, 0, 0, 0, 8'h11};
        tbl[1]  = '{1, 1, 1, 1, 0, 0, 1, 8'h11};
        tbl[2]  = '{1, 1, 1, 1, 0, 0, 1, 8'h11};
        tbl[3]  = '{1, 1, 1, 1, 0, 0, 1, 8'h11};
        tbl[4]  = '{1, 1, 1, 1, 0, 0, 1, 8'h11};
        tbl[5]  = '{1, 1, 1, 0, 1, 1, 1, 8'h22};
        tbl[6]  = '{1, 1, 0, 0, 0, 1, 1, 8'h22};
        tbl[7]  = '{1, 1, 0, 0, 0, 1, 1, 8'h22};
        tbl[8]  = '{1, 1, 0, 0, 0, 1, 1, 8'h22};
        tbl[9]  = '{1, 1, 0, 0, 0, 1, 1, 8'h22};
        tbl[10] = '{1, 1, 0, 0, 0, 1, 1, 8'h22};
        tbl[11] = '{1, 1, 1, 0, 1, 1, 1, 8'h22};
        tbl[12] = '{1, 1, 1, 0, 1, 1, 1, 8'h22};
        tbl[13] = '{1, 1, 1, 0, 1, 1, 1, 8'h22};
        tbl[14] = '{1, 1, 1, 1, 0, 0, 1, 8'h11};
        tbl[15] = '{0, 1, 1, 0, 0, 0, 0, 8'h11};
        tbl[16] = '{0, 1, 1, 0, 1, 1, 1, 8'h22};
        tbl[17] = '{0, 0, 1, 0, 0, 1, 0, 8'h22};
        tbl[18] = '{0, 0, 1, 0, 0, 1, 0, 8'h22};
        tbl[19] = '{0, 1, 1, 0, 0, 1, 0, 8'h22};
        tbl[20] = '{0, 1, 1, 0, 1, 1, 1, 8'h22};

        do_reset();
        for (int i = 0; i < 21; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].v0, tbl[i].v1, 8'h11, 8'h22, tbl[i].ordy,
                 tbl[i].r0, tbl[i].r1, tbl[i].sel, tbl[i].ov, tbl[i].od);
        end

        // Single requester: first beat one cycle after valid is sampled.
        do_reset();
        step("a5_idle", 1, 0, 8'hA5, 8'h00, 1, 0, 0, 0, 0, 8'hA5);
        step("a5_beat", 1, 0, 8'hA5, 8'h00, 1, 1, 0, 0, 1, 8'hA5);

        // Requester 0 drops valid after 2 beats; requester 1 takes over.
        do_reset();
        step("drop_idle", 1, 1, 8'h10, 8'h20, 1, 0, 0, 0, 0, 8'h10);
        step("drop_b1", 1, 1, 8'h10, 8'h20, 1, 1, 0, 0, 1, 8'h10);
        step("drop_b2", 1, 1, 8'h10, 8'h20, 1, 1, 0, 0, 1, 8'h10);
        step("drop_gap", 0, 1, 8'h10, 8'h20, 1, 0, 0, 0, 0, 8'h10);
        step("drop_hand", 0, 1, 8'h10, 8'h20, 1, 0, 1, 1, 1, 8'h20);

        // Asynchronous reset in the middle of a GNT1 burst.
        do_reset();
        step("ar_idle", 0, 1, 8'h44, 8'h55, 1, 0, 0, 0, 0, 8'h44);
        step("ar_g1", 0, 1, 8'h44, 8'h55, 1, 0, 1, 1, 1, 8'h55);
        reset = 1'b1;
        #1;
        chk("ar_sel", 32'(sel), 32'd0);
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_ready1", 32'(ready1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("ar_post_idle", 1, 1, 8'h44, 8'h55, 1, 0, 0, 0, 0, 8'h44);
        step("ar_post_g0", 1, 1, 8'h44, 8'h55, 1, 1, 0, 0, 1, 8'h44);

`ifdef MUX2_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step("st0", 1, 0, 8'h01, 8'h02, 1, i > 0, 0, 0, i > 0, 8'h01);
        end
        step("st_gap", 0, 1, 8'h01, 8'h02, 1, 0, 0, 0, 0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step("st1", 0, 1, 8'h01, 8'h02, 1, 0, 1, 1, 1, 8'h02);
        end
        step("st_end", 0, 0, 8'h01, 8'h02, 1, 0, 0, 1, 0, 8'h02);
        chk("stats_beats0", 32'(beats0), 32'd10);
        chk("stats_beats1", 32'(beats1), 32'd3);
`endif

        // Randomized traffic: requesters hold each beat until accepted.
        void'($urandom(32'd12345));
        do_reset();
        model_reset();
        h0  = 1'b0;
        h1  = 1'b0;
        rd0 = 8'h00;
        rd1 = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if (!h0 && ($urandom_range(99) < 60)) begin h0 = 1'b1; rd0 = 8'($urandom); end
            if (!h1 && ($urandom_range(99) < 60)) begin h1 = 1'b1; rd1 = 8'($urandom); end
            valid0    = h0;
            valid1    = h1;
            data0     = rd0;
            data1     = rd1;
            out_ready = ($urandom_range(99) < 75);
            #1;
            e_ov = (m_owner == 0) ? h0 : (m_owner == 1) ? h1 : 1'b0;
            e_r0 = (m_owner == 0) && h0 && out_ready;
            e_r1 = (m_owner == 1) && h1 && out_ready;
            e_od = m_sel ? rd1 : rd0;
            chk($sformatf("rnd%0d_ready0", c), 32'(ready0), 32'(e_r0));
            chk($sformatf("rnd%0d_ready1", c), 32'(ready1), 32'(e_r1));
            chk($sformatf("rnd%0d_sel", c), 32'(sel), 32'(m_sel));
            chk($sformatf("rnd%0d_out_valid", c), 32'(out_valid), 32'(e_ov));
            chk($sformatf("rnd%0d_out_data", c), 32'(out_data), 32'(e_od));
            model_step(h0, h1, out_ready);
            if (e_r0) h0 = 1'b0;
            if (e_r1) h1 = 1'b0;
            @(negedge clk);
        end
`ifdef MUX2_ARB_STATS_EN
        chk("rnd_beats0", 32'(beats0), 32'(m_b0 % 65536));
        chk("rnd_beats1", 32'(beats1), 32'(m_b1 % 65536));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
